// File: rtl/csi2_data_types_pkg.sv
// rtl/csi2_data_types_pkg.sv - shared types for the CSI-2 frame capture path
// Purpose: stream widths, frame error codes and frame-sequencer state encoding.
// Ports: none (package).
package csi2_data_types_pkg;
   localparam int AXIS_DATA_W = 32;
   localparam int AXIS_KEEP_W = AXIS_DATA_W / 8;

   typedef enum logic [2:0] {
      ERR_NONE          = 3'd0,
      ERR_FS_IN_FRAME   = 3'd1,
      ERR_FE_NO_FS      = 3'd2,
      ERR_LINE_MISMATCH = 3'd3,
      ERR_TIMEOUT       = 3'd4
   } frame_err_t;

   typedef enum logic [1:0] {
      IDLE_S    = 2'd0,
      WAIT_FS_S = 2'd1,
      CAPTURE_S = 2'd2
   } frame_ctrl_state_t;
endpackage

// File: rtl/csi2_frame_watchdog.sv
// rtl/csi2_frame_watchdog.sv - idle-cycle watchdog for the frame sequencer
// Purpose: counts idle cycles while enabled; pulses expired_o on the cycle the
//          count reaches limit_i-1. limit_i of zero disables expiry.
// Ports:
//   clk_i, rst_i  clock, asynchronous active-high reset
//   en_i          count enable (held in reset when low)
//   clr_i         restart count (activity seen this cycle)
//   limit_i       idle-cycle limit
//   expired_o     1-cycle expiry pulse (combinational)
module csi2_frame_watchdog #(
   parameter int TMO_W = 24
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  logic             clr_i,
   input  logic [TMO_W-1:0] limit_i,
   output logic             expired_o
);
   logic [TMO_W-1:0] cnt;

   // Activity in the same cycle wins over expiry.
   assign expired_o = en_i && !clr_i && (limit_i != '0) && (cnt == limit_i - TMO_W'(1));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt <= '0;
      end else if (!en_i || clr_i || expired_o) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + TMO_W'(1);
      end
   end
endmodule

// File: rtl/csi2_frame_ctrl.sv
// rtl/csi2_frame_ctrl.sv - CSI-2 frame-capture sequencer and payload gate
// Purpose: arms on command, opens the payload stream at frame start, closes it
//          at frame end, counts lines and reports completion and errors.
//          Gate changes only between packets so no packet is truncated.
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   arm_i, continuous_i, stop_i  software control
//   exp_lines_i, timeout_i       expected lines (0 = no check), watchdog limit (0 = off)
//   frame_start_i, frame_end_i   1-cycle pulses from the packet handler
//   pkt_i_*                      payload stream in (slave)
//   pkt_o_*                      gated payload stream out (master)
//   busy_o, frame_done_o, frame_err_o, err_code_o, line_cnt_o, frame_cnt_o  status
module csi2_frame_ctrl
   import csi2_data_types_pkg::*;
#(
   parameter int LINE_CNT_W = 16,
   parameter int TMO_W      = 24
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   arm_i,
   input  logic                   continuous_i,
   input  logic                   stop_i,
   input  logic [LINE_CNT_W-1:0]  exp_lines_i,
   input  logic [TMO_W-1:0]       timeout_i,
   input  logic                   frame_start_i,
   input  logic                   frame_end_i,
   input  logic [AXIS_DATA_W-1:0] pkt_i_tdata,
   input  logic [AXIS_KEEP_W-1:0] pkt_i_tstrb,
   input  logic [AXIS_KEEP_W-1:0] pkt_i_tkeep,
   input  logic                   pkt_i_tlast,
   input  logic                   pkt_i_tvalid,
   output logic                   pkt_i_tready,
   output logic [AXIS_DATA_W-1:0] pkt_o_tdata,
   output logic [AXIS_KEEP_W-1:0] pkt_o_tstrb,
   output logic [AXIS_KEEP_W-1:0] pkt_o_tkeep,
   output logic                   pkt_o_tlast,
   output logic                   pkt_o_tvalid,
   input  logic                   pkt_o_tready,
   output logic                   busy_o,
   output logic                   frame_done_o,
   output logic                   frame_err_o,
   output logic [2:0]             err_code_o,
   output logic [LINE_CNT_W-1:0]  line_cnt_o,
   output logic [LINE_CNT_W-1:0]  frame_cnt_o
);
   frame_ctrl_state_t     state, state_n;
   frame_err_t            err_code, err_n, code;
   logic                  gate, gate_want, gate_want_n, in_pkt;
   logic                  stop_l, stop_n, cont_l, cont_n;
   logic                  done_q, done_n, errp_q, errp_n;
   logic [LINE_CNT_W-1:0] line_cnt, line_n, frame_cnt, frame_n, lines_now;
   logic                  acc, out_last, gate_upd, tmo_expired;

   // Closed gate sinks everything so the packet handler never stalls.
   assign pkt_i_tready = gate ? pkt_o_tready : 1'b1;
   assign pkt_o_tvalid = gate & pkt_i_tvalid;
   assign pkt_o_tdata  = pkt_i_tdata;
   assign pkt_o_tstrb  = pkt_i_tstrb;
   assign pkt_o_tkeep  = pkt_i_tkeep;
   assign pkt_o_tlast  = pkt_i_tlast;

   assign acc       = pkt_i_tvalid & pkt_i_tready;
   assign out_last  = gate & acc & pkt_i_tlast;
   // Gate may move only where no packet is open after this cycle; a beat that
   // opens a packet this cycle must keep the gate it started under.
   assign gate_upd  = acc ? pkt_i_tlast : !in_pkt;
   assign lines_now = line_cnt + LINE_CNT_W'(out_last);

   csi2_frame_watchdog #(.TMO_W(TMO_W)) u_wdog (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .en_i      (state != IDLE_S),
      .clr_i     (acc | frame_start_i | frame_end_i),
      .limit_i   (timeout_i),
      .expired_o (tmo_expired)
   );

   always_comb begin
      state_n     = state;
      gate_want_n = gate_want;
      line_n      = line_cnt;
      frame_n     = frame_cnt;
      err_n       = err_code;
      done_n      = 1'b0;
      errp_n      = 1'b0;
      stop_n      = stop_l | stop_i;
      cont_n      = cont_l;
      code        = ERR_NONE;
      case (state)
         IDLE_S: begin
            stop_n = 1'b0;
            if (arm_i && !stop_i) begin
               state_n   = WAIT_FS_S;
               line_n    = '0;
               frame_n   = '0;
               err_n     = ERR_NONE;
               cont_n    = continuous_i;
            end
         end
         WAIT_FS_S: begin
            if (tmo_expired) begin
               code        = ERR_TIMEOUT;
               gate_want_n = 1'b0;
               state_n     = IDLE_S;
            end else begin
               if (frame_end_i) code = ERR_FE_NO_FS;
               if (stop_n) begin
                  state_n = IDLE_S;
               end else if (frame_start_i) begin
                  state_n     = CAPTURE_S;
                  gate_want_n = 1'b1;
                  line_n      = '0;
               end
            end
         end
         CAPTURE_S: begin
            line_n = lines_now;
            if (tmo_expired) begin
               code        = ERR_TIMEOUT;
               done_n      = 1'b1;
               frame_n     = frame_cnt + LINE_CNT_W'(1);
               gate_want_n = 1'b0;
               state_n     = IDLE_S;
            end else if (frame_end_i) begin
               done_n      = 1'b1;
               frame_n     = frame_cnt + LINE_CNT_W'(1);
               gate_want_n = 1'b0;
               if (exp_lines_i != '0 && lines_now != exp_lines_i) code = ERR_LINE_MISMATCH;
               // A same-cycle FS after FE starts the next frame when re-arming.
               if (cont_l && !stop_n) begin
                  state_n = WAIT_FS_S;
                  if (frame_start_i) begin
                     state_n     = CAPTURE_S;
                     gate_want_n = 1'b1;
                     line_n      = '0;
                  end
               end else begin
                  state_n = IDLE_S;
               end
            end else if (frame_start_i) begin
               code    = ERR_FS_IN_FRAME;
               done_n  = 1'b1;
               frame_n = frame_cnt + LINE_CNT_W'(1);
               line_n  = '0;
            end
         end
         default: state_n = IDLE_S;
      endcase
      if (code != ERR_NONE) begin
         err_n  = code;
         errp_n = 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state     <= IDLE_S;
         err_code  <= ERR_NONE;
         gate      <= 1'b0;
         gate_want <= 1'b0;
         in_pkt    <= 1'b0;
         stop_l    <= 1'b0;
         cont_l    <= 1'b0;
         done_q    <= 1'b0;
         errp_q    <= 1'b0;
         line_cnt  <= '0;
         frame_cnt <= '0;
      end else begin
         state     <= state_n;
         err_code  <= err_n;
         gate_want <= gate_want_n;
         stop_l    <= stop_n;
         cont_l    <= cont_n;
         done_q    <= done_n;
         errp_q    <= errp_n;
         line_cnt  <= line_n;
         frame_cnt <= frame_n;
         if (acc)      in_pkt <= !pkt_i_tlast;
         if (gate_upd) gate   <= gate_want_n;
      end
   end

   assign busy_o       = (state != IDLE_S);
   assign frame_done_o = done_q;
   assign frame_err_o  = errp_q;
   assign err_code_o   = err_code;
   assign line_cnt_o   = line_cnt;
   assign frame_cnt_o  = frame_cnt;
endmodule

// File: tb/tb_csi2_frame_ctrl.sv
// tb/tb_csi2_frame_ctrl.sv - scoreboard bench for csi2_frame_ctrl
module tb_csi2_frame_ctrl;
   localparam int LW = 16;
   localparam int TW = 24;

   logic          clk = 1'b0;
   logic          rst;
   logic          arm_i, continuous_i, stop_i, frame_start_i, frame_end_i;
   logic [LW-1:0] exp_lines_i;
   logic [TW-1:0] timeout_i;
   logic [31:0]   pkt_i_tdata, pkt_o_tdata;
   logic [3:0]    pkt_i_tstrb, pkt_i_tkeep, pkt_o_tstrb, pkt_o_tkeep;
   logic          pkt_i_tlast, pkt_i_tvalid, pkt_i_tready;
   logic          pkt_o_tlast, pkt_o_tvalid, pkt_o_tready;
   logic          busy_o, frame_done_o, frame_err_o;
   logic [2:0]    err_code_o;
   logic [LW-1:0] line_cnt_o, frame_cnt_o;

   typedef struct { logic [31:0] data; logic [3:0] keep; logic last; } beat_t;
   typedef struct { bit done; bit err; int code; int lines; int fcnt; longint cyc; } ev_t;

   beat_t  exp_q[$];
   ev_t    ev_q[$];
   int     checks = 0;
   int     failures = 0;
   int     out_beats = 0;
   int     out_lasts = 0;
   longint cyc = 0;
   bit     bp_en = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   csi2_frame_ctrl #(.LINE_CNT_W(LW), .TMO_W(TW)) dut (
      .clk_i(clk), .rst_i(rst), .arm_i(arm_i), .continuous_i(continuous_i), .stop_i(stop_i),
      .exp_lines_i(exp_lines_i), .timeout_i(timeout_i),
      .frame_start_i(frame_start_i), .frame_end_i(frame_end_i),
      .pkt_i_tdata(pkt_i_tdata), .pkt_i_tstrb(pkt_i_tstrb), .pkt_i_tkeep(pkt_i_tkeep),
      .pkt_i_tlast(pkt_i_tlast), .pkt_i_tvalid(pkt_i_tvalid), .pkt_i_tready(pkt_i_tready),
      .pkt_o_tdata(pkt_o_tdata), .pkt_o_tstrb(pkt_o_tstrb), .pkt_o_tkeep(pkt_o_tkeep),
      .pkt_o_tlast(pkt_o_tlast), .pkt_o_tvalid(pkt_o_tvalid), .pkt_o_tready(pkt_o_tready),
      .busy_o(busy_o), .frame_done_o(frame_done_o), .frame_err_o(frame_err_o),
      .err_code_o(err_code_o), .line_cnt_o(line_cnt_o), .frame_cnt_o(frame_cnt_o)
   );

   task automatic chk(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic push_ev(input bit done, input bit err, input int code,
                          input int lines, input int fcnt, input longint at);
      ev_t e;
      e.done = done; e.err = err; e.code = code; e.lines = lines; e.fcnt = fcnt; e.cyc = at;
      ev_q.push_back(e);
   endtask

   // Downstream backpressure, changed just after each active edge.
   always @(posedge clk) begin
      #1;
      pkt_o_tready = bp_en ? ($urandom_range(0, 3) != 0) : 1'b1;
   end

   // Beat monitor: every accepted output beat must be the next expected one.
   always @(negedge clk) begin
      beat_t b;
      if (!rst && pkt_o_tvalid && pkt_o_tready) begin
         out_beats++;
         if (pkt_o_tlast) out_lasts++;
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL beat_unexpected actual=%h required=none", pkt_o_tdata);
         end else begin
            b = exp_q.pop_front();
            chk("beat", {pkt_o_tkeep, pkt_o_tlast, pkt_o_tdata}, {b.keep, b.last, b.data});
            chk("beat_strb", pkt_o_tstrb, b.keep);
         end
      end
   end

   // Event monitor: done/err pulses against the expected event queue.
   always @(negedge clk) begin
      ev_t e;
      if (!rst && (frame_done_o || frame_err_o)) begin
         if (ev_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL event_unexpected actual=done%0d/err%0d required=none", frame_done_o, frame_err_o);
         end else begin
            e = ev_q.pop_front();
            chk("ev_done", frame_done_o, e.done);
            chk("ev_err", frame_err_o, e.err);
            chk("ev_code", err_code_o, e.code);
            chk("ev_lines", line_cnt_o, e.lines);
            chk("ev_fcnt", frame_cnt_o, e.fcnt);
            if (e.cyc >= 0) chk("ev_time", cyc, e.cyc);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle(input int n);
      repeat (n) tick();
   endtask

   task automatic pulse_fs();
      frame_start_i = 1'b1; tick(); frame_start_i = 1'b0;
   endtask

   task automatic pulse_fe();
      frame_end_i = 1'b1; tick(); frame_end_i = 1'b0;
   endtask

   task automatic do_arm(output longint at);
      arm_i = 1'b1; tick(); arm_i = 1'b0;
      at = cyc;
   endtask

   // One packet; pass selects whether the model expects it downstream.
   task automatic send_pkt(input int n, input bit pass, input int stop_at);
      beat_t b;
      int    waits;
      bit    ok;
      for (int i = 0; i < n; i++) begin
         b.data = $urandom;
         b.keep = 4'($urandom_range(1, 15));
         b.last = (i == n - 1);
         pkt_i_tvalid = 1'b1;
         pkt_i_tdata  = b.data;
         pkt_i_tkeep  = b.keep;
         pkt_i_tstrb  = b.keep;
         pkt_i_tlast  = b.last;
         if (i == stop_at) stop_i = 1'b1;
         if (pass) exp_q.push_back(b);
         waits = 0;
         ok = 1'b0;
         while (!ok) begin
            @(negedge clk);
            if (!pass && waits == 0) begin
               chk("drop_tvalid", pkt_o_tvalid, 0);
               chk("drop_tready", pkt_i_tready, 1);
            end
            ok = pkt_i_tready;
            @(posedge clk);
            #1;
            waits++;
            if (!ok && waits > 1000) begin
               checks++;
               failures++;
               $display("FAIL beat_accept_timeout actual=%0d required<=1000", waits);
               ok = 1'b1;
            end
         end
         stop_i = 1'b0;
         pkt_i_tvalid = 1'b0;
         if ($urandom_range(0, 3) == 0) tick();
      end
   endtask

   task automatic send_line(input int n, input bit pass);
      send_pkt(n, pass, -1);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout actual=%0d required=finished", cyc);
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "global timeout");
   end

   initial begin
      longint at;
      int     b0, l0, n, sel, expn, code;
      rst = 1'b1;
      arm_i = 0; continuous_i = 0; stop_i = 0; frame_start_i = 0; frame_end_i = 0;
      exp_lines_i = '0; timeout_i = '0;
      pkt_i_tdata = '0; pkt_i_tstrb = '0; pkt_i_tkeep = '0; pkt_i_tlast = 0;
      pkt_i_tvalid = 1'b1;
      pkt_o_tready = 1'b1;
      settle(3);
      chk("rst_busy", busy_o, 0);
      chk("rst_done", frame_done_o, 0);
      chk("rst_err", frame_err_o, 0);
      chk("rst_code", err_code_o, 0);
      chk("rst_line", line_cnt_o, 0);
      chk("rst_frame", frame_cnt_o, 0);
      chk("rst_out_valid", pkt_o_tvalid, 0);
      chk("rst_in_ready", pkt_i_tready, 1);
      pkt_i_tvalid = 1'b0;
      tick();
      rst = 1'b0;
      settle(2);

      // Basic single-shot frame: 4 lines of 8 beats.
      exp_lines_i = 4;
      b0 = out_beats; l0 = out_lasts;
      do_arm(at);
      settle(2);
      pulse_fs();
      for (int i = 0; i < 4; i++) send_line(8, 1);
      push_ev(1, 0, 0, 4, 1, -1);
      pulse_fe();
      settle(3);
      chk("t1_beats", out_beats - b0, 32);
      chk("t1_lasts", out_lasts - l0, 4);
      chk("t1_busy", busy_o, 0);
      chk("t1_code", err_code_o, 0);
      chk("t1_frames", frame_cnt_o, 1);

      // Lines before frame start are discarded.
      do_arm(at);
      for (int i = 0; i < 3; i++) send_line(4, 0);
      pulse_fs();
      for (int i = 0; i < 4; i++) send_line(8, 1);
      push_ev(1, 0, 0, 4, 1, -1);
      pulse_fe();
      settle(3);
      chk("t2_busy", busy_o, 0);

      // Line count mismatch.
      exp_lines_i = 5;
      do_arm(at);
      pulse_fs();
      for (int i = 0; i < 4; i++) send_line($urandom_range(1, 8), 1);
      push_ev(1, 1, 3, 4, 1, -1);
      pulse_fe();
      settle(3);
      chk("t3_code", err_code_o, 3);
      chk("t3_lines", line_cnt_o, 4);

      // Watchdog with no traffic after arm.
      exp_lines_i = 0;
      timeout_i = 100;
      do_arm(at);
      push_ev(0, 1, 4, 0, 0, at + 100);
      for (int i = 0; i < 200 && ev_q.size() != 0; i++) tick();
      settle(2);
      chk("t4_busy", busy_o, 0);
      chk("t4_code", err_code_o, 4);
      timeout_i = 0;

      // Continuous mode, stop mid-line in the third frame.
      continuous_i = 1;
      exp_lines_i = 2;
      bp_en = 1'b1;
      do_arm(at);
      continuous_i = 0;
      for (int f = 1; f <= 3; f++) begin
         pulse_fs();
         send_line($urandom_range(2, 6), 1);
         if (f == 3) send_pkt(6, 1, 2);
         else        send_line($urandom_range(1, 6), 1);
         push_ev(1, 0, 0, 2, f, -1);
         pulse_fe();
         settle(2);
         if (f < 3) chk("t5_rearmed", busy_o, 1);
      end
      settle(2);
      chk("t5_busy", busy_o, 0);
      chk("t5_frames", frame_cnt_o, 3);

      // Frame start inside a frame, under backpressure.
      exp_lines_i = 0;
      do_arm(at);
      pulse_fs();
      for (int i = 0; i < 3; i++) send_line($urandom_range(1, 6), 1);
      push_ev(1, 1, 1, 0, 1, -1);
      pulse_fs();
      for (int i = 0; i < 2; i++) send_line($urandom_range(1, 6), 1);
      push_ev(1, 0, 1, 2, 2, -1);
      pulse_fe();
      settle(3);
      chk("t6_code", err_code_o, 1);
      chk("t6_busy", busy_o, 0);

      // Random single-shot frames against the line-count rule.
      for (int k = 0; k < 4; k++) begin
         n = $urandom_range(1, 5);
         sel = $urandom_range(0, 2);
         expn = (sel == 0) ? 0 : (sel == 1) ? n : n + 1;
         exp_lines_i = LW'(expn);
         code = (expn != 0 && expn != n) ? 3 : 0;
         do_arm(at);
         if ($urandom_range(0, 1) == 1) send_line($urandom_range(1, 4), 0);
         pulse_fs();
         for (int i = 0; i < n; i++) send_line($urandom_range(1, 6), 1);
         push_ev(1, code != 0, code, n, 1, -1);
         pulse_fe();
         settle(3);
      end

      settle(5);
      chk("beats_drained", exp_q.size(), 0);
      chk("events_drained", ev_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
